// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: turns PCF into InstrF through a req/ready, rvalid
// memory handshake, holding the current instruction plus a sequential prefetch.
module instr_fetch_unit #(
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
  parameter bit          PREFETCH_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  input  logic        redirect,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] InstrF,
  output logic        fetch_valid,
  output logic        fetch_stall
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t      r_state;
  logic        r_cur_v, r_nxt_v;
  logic [31:0] r_cur_addr, r_cur_data;
  logic [31:0] r_nxt_addr, r_nxt_data;
  logic [31:0] r_req_addr;

  logic        w_cur_hit, w_nxt_hit, w_pf_held, w_req;
  logic [31:0] w_pf_addr, w_fetch_addr;

  assign w_cur_hit = r_cur_v && (r_cur_addr == PCF);
  assign w_nxt_hit = r_nxt_v && (r_nxt_addr == PCF);
  assign w_pf_addr = PCF + 32'd4;
  assign w_pf_held = r_nxt_v && (r_nxt_addr == w_pf_addr);

  // Requests are only launched from IDLE, and never while reset is asserted,
  // so a memory cannot accept a transaction the FSM is not tracking.
  always_comb begin
    w_req        = 1'b0;
    w_fetch_addr = PCF;
    if (reset && (r_state == S_IDLE) && !redirect) begin
      if (!w_cur_hit && !w_nxt_hit) begin
        w_req = 1'b1;
      end else if (PREFETCH_EN && w_cur_hit && !w_pf_held) begin
        w_req        = 1'b1;
        w_fetch_addr = w_pf_addr;
      end
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = w_fetch_addr & 32'hFFFF_FFFC;
  assign fetch_valid = w_cur_hit || w_nxt_hit;
  assign fetch_stall = !fetch_valid;
  assign InstrF      = w_cur_hit ? r_cur_data :
                       w_nxt_hit ? r_nxt_data : NOP_INSTR;

  // NOTE: slot address/data registers are deliberately left out of reset; the
  // valid bits gate every use of them, so only the control state is cleared.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cur_v    <= 1'b0;
      r_nxt_v    <= 1'b0;
      r_req_addr <= '0;
    end else begin
      if (w_nxt_hit && !w_cur_hit) begin
        r_cur_v    <= 1'b1;
        r_cur_addr <= r_nxt_addr;
        r_cur_data <= r_nxt_data;
        r_nxt_v    <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_req && imem_ready) begin
            r_req_addr <= imem_addr;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            r_state <= S_IDLE;
            if (!redirect) begin
              if (r_req_addr == PCF) begin
                r_cur_v    <= 1'b1;
                r_cur_addr <= r_req_addr;
                r_cur_data <= imem_rdata;
              end else begin
                r_nxt_v    <= 1'b1;
                r_nxt_addr <= r_req_addr;
                r_nxt_data <= imem_rdata;
              end
            end
          end else if (redirect) begin
            r_state <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (imem_rvalid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // A taken branch/jump invalidates both slots, overriding fills above.
      if (redirect) begin
        r_cur_v <= 1'b0;
        r_nxt_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized core/memory
// environment checked against an epoch-tagged memory image.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        redirect, imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_req, fetch_valid, fetch_stall;
  logic [31:0] imem_addr, InstrF;

  logic [31:0] np_pcf;
  logic        np_redirect, np_ready, np_rvalid;
  logic [31:0] np_rdata;
  logic        np_req, np_valid, np_stall;
  logic [31:0] np_addr, np_instr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.NOP_INSTR(NOP), .PREFETCH_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .PCF(PCF), .redirect(redirect),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr), .InstrF(InstrF),
    .fetch_valid(fetch_valid), .fetch_stall(fetch_stall)
  );

  instr_fetch_unit #(.NOP_INSTR(NOP), .PREFETCH_EN(1'b0)) dut_np (
    .clk(clk), .reset(reset), .PCF(np_pcf), .redirect(np_redirect),
    .imem_ready(np_ready), .imem_rvalid(np_rvalid), .imem_rdata(np_rdata),
    .imem_req(np_req), .imem_addr(np_addr), .InstrF(np_instr),
    .fetch_valid(np_valid), .fetch_stall(np_stall)
  );

  // Memory image: content depends on address and on the redirect epoch in
  // which the request was accepted, so stale data is always distinguishable.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input int unsigned ep);
    return (a ^ (ep << 20)) * 32'h9E37_79B1;
  endfunction

  task automatic cyc(input logic rst, input logic [31:0] pc, input logic redir,
                     input logic rdy, input logic rv, input logic [31:0] rd);
    @(negedge clk);
    reset = rst; PCF = pc; redirect = redir;
    imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
    #1;
  endtask

  task automatic cyc_np(input logic [31:0] pc, input logic rdy, input logic rv,
                        input logic [31:0] rd);
    @(negedge clk);
    np_pcf = pc; np_ready = rdy; np_rvalid = rv; np_rdata = rd;
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b0, 32'h40, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 32'h40, 1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_vec++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL rst_stall: got %b want 1", fetch_stall); end
    n_vec++; if (InstrF !== NOP) begin n_err++; $display("FAIL rst_instr: got %h want %h", InstrF, NOP); end
    cyc(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_err++; $display("FAIL rst_first_req: got %b/%h want 1/00000040", imem_req, imem_addr); end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 32'h40, 1'b0, 1'b1, (k < 2), 32'hDEAD_BEEF);
      n_vec++; if (imem_req !== 1'b0 || fetch_stall !== 1'b1) begin n_err++; $display("FAIL rst_mid_wait[%0d]: req/stall got %b/%b want 0/1", k, imem_req, fetch_stall); end
    end
    cyc(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_err++; $display("FAIL rst_release_req: got %b/%h want 1/00000040", imem_req, imem_addr); end
    n_vec++; if (fetch_valid !== 1'b0 || InstrF !== NOP) begin n_err++; $display("FAIL rst_late_data: valid/instr got %b/%h want 0/%h", fetch_valid, InstrF, NOP); end
  endtask

  task automatic test_miss_latency();
    cyc(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL miss_c0: got %b/%h want 1/00000100", imem_req, imem_addr); end
    cyc(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h0050_0093);
    n_vec++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin n_err++; $display("FAIL miss_c1: req/valid got %b/%b want 0/0", imem_req, fetch_valid); end
    cyc(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++; if (InstrF !== 32'h0050_0093 || fetch_valid !== 1'b1) begin n_err++; $display("FAIL miss_c2_instr: got %h/%b want 00500093/1", InstrF, fetch_valid); end
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin n_err++; $display("FAIL miss_c2_prefetch: got %b/%h want 1/00000104", imem_req, imem_addr); end
  endtask

  task automatic test_sequential();
    cyc(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h00A0_0113);
    n_vec++; if (fetch_valid !== 1'b1 || InstrF !== 32'h0050_0093) begin n_err++; $display("FAIL seq_hold: got %b/%h want 1/00500093", fetch_valid, InstrF); end
    cyc(1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++; if (fetch_valid !== 1'b1 || InstrF !== 32'h00A0_0113) begin n_err++; $display("FAIL seq_nxt_hit: got %b/%h want 1/00a00113", fetch_valid, InstrF); end
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL seq_no_req: got %b want 0", imem_req); end
    cyc(1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++; if (fetch_valid !== 1'b1 || InstrF !== 32'h00A0_0113) begin n_err++; $display("FAIL seq_promoted: got %b/%h want 1/00a00113", fetch_valid, InstrF); end
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin n_err++; $display("FAIL seq_prefetch: got %b/%h want 1/00000108", imem_req, imem_addr); end
  endtask

  task automatic test_redirect();
    cyc(1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 32'h00B0_0193);
    cyc(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h0);
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL redir_idle_req: got %b want 0", imem_req); end
    cyc(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL redir_cleared: got %b/%h want 1/00000100", imem_req, imem_addr); end
    cyc(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h0050_0093);
    cyc(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin n_err++; $display("FAIL redir_setup: got %b/%h want 1/00000104", imem_req, imem_addr); end
    cyc(1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 32'h0);
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL redir_wait_req: got %b want 0", imem_req); end
    cyc(1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0 || InstrF !== NOP) begin n_err++; $display("FAIL redir_discard: req/valid/instr got %b/%b/%h want 0/0/%h", imem_req, fetch_valid, InstrF, NOP); end
    cyc(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'hBAD0_0104);
    n_vec++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin n_err++; $display("FAIL redir_drop: req/valid got %b/%b want 0/0", imem_req, fetch_valid); end
    cyc(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0);
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || InstrF !== NOP) begin n_err++; $display("FAIL redir_new_req: got %b/%h/%h want 1/00000200/%h", imem_req, imem_addr, InstrF, NOP); end
    cyc(1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h00C0_0213);
    n_vec++; if (fetch_valid !== 1'b0 || InstrF !== NOP) begin n_err++; $display("FAIL redir_no_bypass: got %b/%h want 0/%h", fetch_valid, InstrF, NOP); end
    cyc(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0);
    n_vec++; if (fetch_valid !== 1'b1 || InstrF !== 32'h00C0_0213) begin n_err++; $display("FAIL redir_fill: got %b/%h want 1/00c00213", fetch_valid, InstrF); end
  endtask

  task automatic test_ready_stall();
    int n_acc = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
      if (imem_req && imem_ready) n_acc++;
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || fetch_stall !== 1'b1) begin n_err++; $display("FAIL ready_hold[%0d]: req/addr/stall got %b/%h/%b want 1/00000300/1", k, imem_req, imem_addr, fetch_stall); end
    end
    cyc(1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 32'h0);
    if (imem_req && imem_ready) n_acc++;
    n_vec++; if (imem_addr !== 32'h300) begin n_err++; $display("FAIL ready_accept_addr: got %h want 00000300", imem_addr); end
    cyc(1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 32'h0);
    if (imem_req && imem_ready) n_acc++;
    cyc(1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 32'h00D0_0293);
    if (imem_req && imem_ready) n_acc++;
    n_vec++; if (n_acc !== 1) begin n_err++; $display("FAIL ready_accept_count: got %0d want 1", n_acc); end
    cyc(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
    n_vec++; if (fetch_valid !== 1'b1 || InstrF !== 32'h00D0_0293 || fetch_stall !== 1'b0) begin n_err++; $display("FAIL ready_fill: got %b/%h/%b want 1/00d00293/0", fetch_valid, InstrF, fetch_stall); end
  endtask

  task automatic test_no_prefetch();
    cyc_np(32'h0, 1'b1, 1'b0, 32'h0);
    n_vec++; if (np_req !== 1'b1 || np_addr !== 32'h0) begin n_err++; $display("FAIL np_req0: got %b/%h want 1/00000000", np_req, np_addr); end
    cyc_np(32'h0, 1'b1, 1'b1, 32'h0010_0093);
    cyc_np(32'h0, 1'b1, 1'b0, 32'h0);
    n_vec++; if (np_valid !== 1'b1 || np_instr !== 32'h0010_0093) begin n_err++; $display("FAIL np_hit0: got %b/%h want 1/00100093", np_valid, np_instr); end
    n_vec++; if (np_req !== 1'b0) begin n_err++; $display("FAIL np_no_prefetch: got %b/%h want 0", np_req, np_addr); end
    cyc_np(32'h4, 1'b1, 1'b0, 32'h0);
    n_vec++; if (np_valid !== 1'b0 || np_req !== 1'b1 || np_addr !== 32'h4) begin n_err++; $display("FAIL np_req4: valid/req/addr got %b/%b/%h want 0/1/00000004", np_valid, np_req, np_addr); end
    cyc_np(32'h4, 1'b1, 1'b1, 32'h0020_0113);
    cyc_np(32'h4, 1'b1, 1'b0, 32'h0);
    n_vec++; if (np_valid !== 1'b1 || np_instr !== 32'h0020_0113 || np_req !== 1'b0) begin n_err++; $display("FAIL np_hit4: got %b/%h/%b want 1/00200113/0", np_valid, np_instr, np_req); end
  endtask

  task automatic test_random();
    logic [31:0] pc, m_addr, exp_instr, rd;
    int unsigned epoch, m_ep;
    bit          busy, redir, rdy, rv, legal;
    int          rem, stall_run;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    pc = 32'h1000; epoch = 0; busy = 0; rem = 0; stall_run = 0;
    m_addr = '0; m_ep = 0;
    for (int i = 0; i < 2000; i++) begin
      redir = ($urandom_range(0, 15) == 0);
      rdy   = ($urandom_range(0, 3) != 0) || (stall_run > 8);
      rv    = busy && (rem == 0);
      rd    = rv ? mem_word(m_addr, m_ep) : $urandom();
      cyc(1'b1, pc, redir, rdy, rv, rd);

      n_vec++; if (fetch_stall !== ~fetch_valid) begin n_err++; $display("FAIL rnd_stall[%0d]: stall %b valid %b", i, fetch_stall, fetch_valid); end
      exp_instr = fetch_valid ? mem_word(pc, epoch) : NOP;
      n_vec++; if (InstrF !== exp_instr) begin n_err++; $display("FAIL rnd_instr[%0d]: pc %h got %h want %h", i, pc, InstrF, exp_instr); end
      legal = !busy && !redir && ((imem_addr == pc) || (imem_addr == pc + 32'd4));
      n_vec++; if (imem_req && !legal) begin n_err++; $display("FAIL rnd_req[%0d]: addr %h pc %h busy %b redir %b", i, imem_addr, pc, busy, redir); end
      n_vec++; if (stall_run > 24) begin n_err++; $display("FAIL rnd_liveness[%0d]: pc %h stalled %0d cycles", i, pc, stall_run); break; end

      if (rv) busy = 0;
      else if (busy) rem--;
      if (imem_req && rdy) begin
        busy = 1; m_addr = imem_addr; m_ep = epoch; rem = $urandom_range(0, 2);
      end
      stall_run = (fetch_valid || redir) ? 0 : stall_run + 1;
      if (redir) begin
        epoch++;
        pc = $urandom_range(0, 32'h3FFFF) << 2;
      end else if (fetch_valid) begin
        pc = pc + 32'd4;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; PCF = '0; redirect = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    np_pcf = '0; np_redirect = 1'b0; np_ready = 1'b0; np_rvalid = 1'b0; np_rdata = '0;
    test_reset();
    test_miss_latency();
    test_sequential();
    test_redirect();
    test_ready_stall();
    test_no_prefetch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
